button_pulse_gen: RTL
=====================

BUTTON_PULSE_GEN -- requirements
Module: button_pulse_gen

Interface
REQ-001 SHALL have parameter DEB_CYCLES, default 500000, debounce interval in clk cycles (5 ms at 100 MHz); legal range 2..2^CNT_W-1.
REQ-002 SHALL have parameter REPEAT_CYCLES, default 25000000, auto-repeat interval in clk cycles (250 ms); legal range 2..2^CNT_W-1.
REQ-003 SHALL have parameter CNT_W, default 25, width of each per-button counter.
REQ-004 SHALL have port clk, input, 1, single system clock; all state changes on its rising edge.
REQ-005 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port btn, input, 5, raw asynchronous buttons, bit map {BtnL, BtnU, BtnD, BtnR, BtnC} = btn[4:0].
REQ-007 SHALL have port db, output, 5, debounced level per button.
REQ-008 SHALL have port scen, output, 5, single-cycle pulse per accepted press.
REQ-009 SHALL have port mcen, output, 5, single-cycle pulse on press, then one pulse per REPEAT_CYCLES while held.

Function
REQ-010 SHALL run five identical, independent channels; channel i uses only btn[i] and drives only db[i], scen[i], mcen[i].
REQ-011 SHALL pass each btn[i] through a two-flop synchronizer; s = second flop; the FSM uses only s.
REQ-012 SHALL implement states IDLE, WQ (wait quiet), SCEN, HOLD, MCEN, WR (wait release), plus one counter cnt of CNT_W bits per channel.
REQ-013 IDLE: cnt=0; s=1 -> WQ with cnt=0; else stay.
REQ-014 WQ: s=0 -> IDLE with cnt=0; s=1 and cnt==DEB_CYCLES-1 -> SCEN with cnt=0; else cnt+1.
REQ-015 SCEN: unconditional -> HOLD with cnt=0.
REQ-016 HOLD: s=0 -> WR with cnt=0; s=1 and cnt==REPEAT_CYCLES-1 -> MCEN with cnt=0; else cnt+1.
REQ-017 MCEN: unconditional -> HOLD with cnt=0.
REQ-018 WR: s=1 -> HOLD with cnt=0, with no new scen/mcen; s=0 and cnt==DEB_CYCLES-1 -> IDLE with cnt=0; else cnt+1.
REQ-019 Outputs SHALL be Moore decodes of the state register: db=1 in SCEN, HOLD, MCEN, WR; scen=1 only in SCEN; mcen=1 in SCEN and MCEN.
REQ-020 Latency: with btn[i] steady high, calling the first clk edge that samples it edge 1, scen[i]/mcen[i] SHALL be high for exactly the cycle following edge DEB_CYCLES+3.
REQ-021 While held, mcen SHALL pulse every REPEAT_CYCLES+1 cycles after the SCEN pulse; scen SHALL pulse once per press only.
REQ-022 Glitches shorter than DEB_CYCLES synchronized cycles SHALL produce no output change, whether on press (WQ) or release (WR).
REQ-023 The counter SHALL never wrap: every terminal compare resets it to 0 on the same edge.
REQ-024 Simultaneous presses on several channels SHALL be handled independently, and coincident pulses are allowed.

Reset
REQ-025 reset=0 SHALL immediately force all channels to IDLE, cnt=0, both synchronizer flops to 0, and db=scen=mcen=5'b00000, independent of clk.
REQ-026 Reset asserted mid-press SHALL abort the press; after release of reset, a still-held button SHALL restart the full debounce from IDLE.
REQ-027 Reset release SHALL be synchronized externally; the first post-reset edge SHALL treat s as 0.

Verification (DEB_CYCLES=4, REPEAT_CYCLES=8)
REQ-028 btn=5'b00001 held 20 cycles -> scen[0] high exactly the cycle after edge 7; mcen[0] high then and again 9 cycles later; db[0] high from the cycle after edge 7.
REQ-029 btn[0] high for 3 cycles, then low -> scen, mcen, and db stay 0 throughout.
REQ-030 Accepted press, then a 2-cycle low glitch on btn[0], then high -> db[0] stays 1 and there is no extra scen[0].
REQ-031 btn=5'b10001 rising on the same edge -> scen[4] and scen[0] pulse in the same cycle; other bits stay 0.
REQ-032 reset driven low between clk edges while in HOLD -> outputs 0 at once; reset high with btn held -> scen re-fires 7 edges later.
REQ-033 Release after an accepted press -> db[0] falls the cycle after the 7th edge sampling low (2 synchronizer stages + DEB_CYCLES + 1).

Source files
------------

// File: rtl/button_pulse_gen.sv
// Five-channel push-button conditioner: synchronizes, debounces and produces
// single-shot (scen) and auto-repeat (mcen) enable pulses per button.

module button_pulse_chan #(
    parameter int DEB_CYCLES    = 500000,
    parameter int REPEAT_CYCLES = 25000000,
    parameter int CNT_W         = 25
) (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    output logic db,
    output logic scen,
    output logic mcen
);

    typedef enum logic [2:0] {
        IDLE,
        WQ,
        SCEN,
        HOLD,
        MCEN,
        WR
    } state_t;

    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEB_CYCLES - 1);
    localparam logic [CNT_W-1:0] REP_LAST = CNT_W'(REPEAT_CYCLES - 1);

    logic             sync1_q;
    logic             s_q;
    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             db_q;
    logic             scen_q;
    logic             mcen_q;

    // Every transition that leaves a state, or hits a terminal count, clears cnt.
    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        case (state_q)
            IDLE: begin
                if (s_q) begin
                    state_d = WQ;
                end
            end
            WQ: begin
                if (!s_q) begin
                    state_d = IDLE;
                end else if (cnt_q == DEB_LAST) begin
                    state_d = SCEN;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            SCEN: begin
                state_d = HOLD;
            end
            HOLD: begin
                if (!s_q) begin
                    state_d = WR;
                end else if (cnt_q == REP_LAST) begin
                    state_d = MCEN;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            MCEN: begin
                state_d = HOLD;
            end
            WR: begin
                if (s_q) begin
                    state_d = HOLD;
                end else if (cnt_q == DEB_LAST) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs are decoded from the next state so the registers track state_q exactly.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q <= 1'b0;
            s_q     <= 1'b0;
            state_q <= IDLE;
            cnt_q   <= '0;
            db_q    <= 1'b0;
            scen_q  <= 1'b0;
            mcen_q  <= 1'b0;
        end else begin
            sync1_q <= btn;
            s_q     <= sync1_q;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            db_q    <= (state_d == SCEN) || (state_d == HOLD) ||
                       (state_d == MCEN) || (state_d == WR);
            scen_q  <= (state_d == SCEN);
            mcen_q  <= (state_d == SCEN) || (state_d == MCEN);
        end
    end

    assign db   = db_q;
    assign scen = scen_q;
    assign mcen = mcen_q;

endmodule

module button_pulse_gen #(
    parameter int DEB_CYCLES    = 500000,
    parameter int REPEAT_CYCLES = 25000000,
    parameter int CNT_W         = 25
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] btn,
    output logic [4:0] db,
    output logic [4:0] scen,
    output logic [4:0] mcen
);

    // Bit map {BtnL, BtnU, BtnD, BtnR, BtnC}; channels share nothing but clk/reset.
    for (genvar i = 0; i < 5; i++) begin : g_chan
        button_pulse_chan #(
            .DEB_CYCLES    (DEB_CYCLES),
            .REPEAT_CYCLES (REPEAT_CYCLES),
            .CNT_W         (CNT_W)
        ) u_chan (
            .clk   (clk),
            .reset (reset),
            .btn   (btn[i]),
            .db    (db[i]),
            .scen  (scen[i]),
            .mcen  (mcen[i])
        );
    end

endmodule
